sram_bist_ctrl: RTL and testbench



---
 rtl/sram_bist_pkg.sv | 43 ++++
 rtl/sram_bist_cmp.sv | 18 +
 rtl/sram_bist_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_bist_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST sequencer.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_e;

    typedef logic [2:0] state_e;

    localparam state_e ST_IDLE = 3'd0;
    localparam state_e ST_WR   = 3'd1;
    localparam state_e ST_RD   = 3'd2;
    localparam state_e ST_WT   = 3'd3;
    localparam state_e ST_CMP  = 3'd4;
    localparam state_e ST_FIN  = 3'd5;

    typedef struct packed {
        logic dir_down;
        logic has_read;
        logic rd_bg;
        logic has_write;
        logic wr_bg;
    } march_desc_t;

    localparam int unsigned NumElems = 6;
    localparam march_elem_e LastElem = E5;

    // Entry order is E5 down to E0 so that MarchCTable[E0] is the first element.
    localparam march_desc_t [NumElems-1:0] MarchCTable = {
        march_desc_t'{dir_down: 1'b0, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b0, wr_bg: 1'b0},
        march_desc_t'{dir_down: 1'b1, has_read: 1'b1, rd_bg: 1'b1, has_write: 1'b1, wr_bg: 1'b0},
        march_desc_t'{dir_down: 1'b1, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b1},
        march_desc_t'{dir_down: 1'b0, has_read: 1'b1, rd_bg: 1'b1, has_write: 1'b1, wr_bg: 1'b0},
        march_desc_t'{dir_down: 1'b0, has_read: 1'b1, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b1},
        march_desc_t'{dir_down: 1'b0, has_read: 1'b0, rd_bg: 1'b0, has_write: 1'b1, wr_bg: 1'b0}
    };

endpackage

// File: rtl/sram_bist_cmp.sv
// Background generation and read-data comparison for solid-background march tests.
module sram_bist_cmp #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 rd_bg,
    input  logic                 wr_bg,
    input  logic [DataWidth-1:0] rdata,
    output logic [DataWidth-1:0] wdata_c,
    output logic                 mismatch_c
);

    logic [DataWidth-1:0] expected;

    assign expected   = {DataWidth{rd_bg}};
    assign wdata_c    = {DataWidth{wr_bg}};
    assign mismatch_c = (rdata != expected);

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM macro; drives the macro BIST port
// group and reports pass/fail with the first failing address and element.
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int unsigned NumWords  = 512,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output logic [2:0]           fail_elem_o,
    output logic                 bist_en_o,
    output logic                 bist_men_o,
    output logic                 bist_wen_o,
    output logic                 bist_ren_o,
    output logic [AddrWidth-1:0] bist_addr_o,
    output logic [DataWidth-1:0] bist_din_o,
    output logic [DataWidth-1:0] bist_bm_o,
    input  logic [DataWidth-1:0] bist_dout_i
);

    localparam int unsigned WtWidth = (Latency > 2) ? $clog2(Latency) : 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    state_e               state_q, state_d;
    march_elem_e          elem_q, elem_d, elem_nxt;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [WtWidth-1:0]   wt_q, wt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]           fail_elem_q, fail_elem_d;
    logic                 rst_q;
    logic                 step;
    logic                 at_last;
    logic                 mismatch;
    logic                 wen;
    logic [DataWidth-1:0] wdata;

    sram_bist_cmp #(
        .DataWidth (DataWidth)
    ) u_cmp (
        .rd_bg      (MarchCTable[elem_q].rd_bg),
        .wr_bg      (MarchCTable[elem_q].wr_bg),
        .rdata      (bist_dout_i),
        .wdata_c    (wdata),
        .mismatch_c (mismatch)
    );

    assign elem_nxt = march_elem_e'(elem_q + 3'd1);
    assign at_last  = MarchCTable[elem_q].dir_down ? (addr_q == '0) : (addr_q == LastAddr);

    // Next-state logic; step advances the address/element after a write-only or matched cycle.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        wt_d        = wt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        step        = 1'b0;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start_i && !rst_q) begin
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    elem_d      = E0;
                    addr_d      = MarchCTable[E0].dir_down ? LastAddr : '0;
                    busy_d      = 1'b1;
                    state_d     = MarchCTable[E0].has_read ? ST_RD : ST_WR;
                end
            end
            ST_WR: step = 1'b1;
            ST_RD: begin
                if (Latency > 1) begin
                    wt_d    = WtWidth'(Latency - 2);
                    state_d = ST_WT;
                end else begin
                    state_d = ST_CMP;
                end
            end
            ST_WT: begin
                if (wt_q == '0) state_d = ST_CMP;
                else            wt_d    = wt_q - 1'b1;
            end
            ST_CMP: begin
                if (mismatch) begin
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_FIN;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            if (at_last) begin
                if (elem_q == LastElem) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    elem_d  = elem_nxt;
                    addr_d  = MarchCTable[elem_nxt].dir_down ? LastAddr : '0;
                    state_d = MarchCTable[elem_nxt].has_read ? ST_RD : ST_WR;
                end
            end else begin
                addr_d  = MarchCTable[elem_q].dir_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                state_d = MarchCTable[elem_q].has_read ? ST_RD : ST_WR;
            end
        end
    end

    // rst_q masks a start pulse on the first edge after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            elem_q      <= E0;
            addr_q      <= '0;
            wt_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            rst_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            wt_q        <= wt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            rst_q       <= 1'b0;
        end
    end

    // The element write in CMP is gated by the same-cycle compare result.
    assign wen = (state_q == ST_WR) ||
                 ((state_q == ST_CMP) && MarchCTable[elem_q].has_write && !mismatch);

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign bist_en_o   = busy_q;
    assign bist_ren_o  = (state_q == ST_RD);
    assign bist_wen_o  = wen;
    assign bist_men_o  = wen || (state_q == ST_RD);
    assign bist_addr_o = busy_q ? addr_q : '0;
    assign bist_din_o  = wen ? wdata : '0;
    assign bist_bm_o   = {DataWidth{wen}};

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Testbench for sram_bist_ctrl: two instances (16 words/latency 1, 12 words/latency 2)
// against behavioural SRAM models with injectable faults and an algorithmic March C- reference.
module tb_sram_bist_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned NA = 16;
    localparam int unsigned LA = 1;
    localparam int unsigned NB = 12;
    localparam int unsigned LB = 2;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic          start_a = 1'b0, start_b = 1'b0;
    logic          scr_a = 1'b0, scr_b = 1'b0;
    int            mode_a = 0, mode_b = 0;
    logic          a_busy, a_done, a_fail, a_en, a_men, a_wen, a_ren;
    logic          b_busy, b_done, b_fail, b_en, b_men, b_wen, b_ren;
    logic [AW-1:0] a_faddr, a_addr, b_faddr, b_addr;
    logic [2:0]    a_felem, b_felem;
    logic [DW-1:0] a_din, a_bm, a_dout, b_din, b_bm, b_dout;

    sram_bist_ctrl #(.NumWords(NA), .DataWidth(DW), .Latency(LA)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(a_busy), .done_o(a_done),
        .fail_o(a_fail), .fail_addr_o(a_faddr), .fail_elem_o(a_felem), .bist_en_o(a_en),
        .bist_men_o(a_men), .bist_wen_o(a_wen), .bist_ren_o(a_ren), .bist_addr_o(a_addr),
        .bist_din_o(a_din), .bist_bm_o(a_bm), .bist_dout_i(a_dout)
    );

    sram_bist_ctrl #(.NumWords(NB), .DataWidth(DW), .Latency(LB)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(b_busy), .done_o(b_done),
        .fail_o(b_fail), .fail_addr_o(b_faddr), .fail_elem_o(b_felem), .bist_en_o(b_en),
        .bist_men_o(b_men), .bist_wen_o(b_wen), .bist_ren_o(b_ren), .bist_addr_o(b_addr),
        .bist_din_o(b_din), .bist_bm_o(b_bm), .bist_dout_i(b_dout)
    );

    // Fault 1: bit 5 of word 9 reads as 1. Fault 2: writing zeros to word 3 clears bit 0 of word 2.
    function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] v, input int a, input int mode);
        logic [DW-1:0] r;
        r = v;
        if (mode == 1 && a == 9) r[5] = 1'b1;
        return r;
    endfunction

    logic [DW-1:0] mem_a [NA];
    logic [DW-1:0] mem_b [NB];
    logic [DW-1:0] pa, pb0, pb1;

    always @(posedge clk) begin
        if (scr_a) begin
            for (int i = 0; i < int'(NA); i++) mem_a[i] <= DW'($urandom);
        end else if (a_men && a_wen) begin
            mem_a[a_addr] <= (mem_a[a_addr] & ~a_bm) | (a_din & a_bm);
            if (mode_a == 2 && a_addr == 4'd3 && a_din == '0) mem_a[2][0] <= 1'b0;
        end
        if (a_men && a_ren) pa <= fault_rd(mem_a[a_addr], int'(a_addr), mode_a);
    end
    assign a_dout = pa;

    always @(posedge clk) begin
        if (scr_b) begin
            for (int i = 0; i < int'(NB); i++) mem_b[i] <= DW'($urandom);
        end else if (b_men && b_wen) begin
            mem_b[b_addr] <= (mem_b[b_addr] & ~b_bm) | (b_din & b_bm);
            if (mode_b == 2 && b_addr == 4'd3 && b_din == '0) mem_b[2][0] <= 1'b0;
        end
        if (b_men && b_ren) pb0 <= fault_rd(mem_b[b_addr], int'(b_addr), mode_b);
        pb1 <= pb0;
    end
    assign b_dout = pb1;

    // Port-group monitors: access trace, busy cycles, rule violations.
    int         busy_cnt_a = 0, busy_cnt_b = 0, rise_a = 0, rise_b = 0, max_addr_b = 0;
    bit         bprev_a = 0, bprev_b = 0, rprev_b = 0;
    bit         rule_err_a = 0, rule_err_b = 0, wt_err_b = 0;
    logic [40:0] trace_a[$], trace_b[$], exp_q[$];

    always @(negedge clk) begin
        if (a_busy) busy_cnt_a++;
        if (a_busy && !bprev_a) rise_a++;
        bprev_a = a_busy;
        if ((a_ren && a_wen) || a_men != (a_ren | a_wen) || a_en != a_busy ||
            (!a_wen && (a_din != '0 || a_bm != '0)) || (a_wen && a_bm != '1) ||
            (!a_busy && (a_addr != '0 || a_men)))
            rule_err_a = 1;
        if (a_men) trace_a.push_back({a_wen, 8'(a_addr), a_din, a_bm});
    end

    always @(negedge clk) begin
        if (b_busy) busy_cnt_b++;
        if (b_busy && !bprev_b) rise_b++;
        bprev_b = b_busy;
        if ((b_ren && b_wen) || b_men != (b_ren | b_wen) || b_en != b_busy ||
            (!b_wen && (b_din != '0 || b_bm != '0)) || (b_wen && b_bm != '1) ||
            (!b_busy && (b_addr != '0 || b_men)))
            rule_err_b = 1;
        if (rprev_b && b_men) wt_err_b = 1;
        rprev_b = b_ren;
        if (int'(b_addr) > max_addr_b) max_addr_b = int'(b_addr);
        if (b_men) trace_b.push_back({b_wen, 8'(b_addr), b_din, b_bm});
    end

    function automatic bit  done_of(input bit w);  return w ? b_done : a_done;  endfunction
    function automatic bit  fail_of(input bit w);  return w ? b_fail : a_fail;  endfunction
    function automatic bit  busy_of(input bit w);  return w ? b_busy : a_busy;  endfunction
    function automatic int  faddr_of(input bit w); return w ? int'(b_faddr) : int'(a_faddr); endfunction
    function automatic int  felem_of(input bit w); return w ? int'(b_felem) : int'(a_felem); endfunction
    function automatic int  bcnt_of(input bit w);  return w ? busy_cnt_b : busy_cnt_a; endfunction
    function automatic int  rise_of(input bit w);  return w ? rise_b : rise_a; endfunction
    function automatic int  qsize_of(input bit w); return w ? trace_b.size() : trace_a.size(); endfunction
    function automatic logic [40:0] qat_of(input bit w, input int i);
        return w ? trace_b[i] : trace_a[i];
    endfunction

    // Reference: March C- executed word by word on an array; -1 means no read/write.
    int el_down [6] = '{0, 0, 0, 1, 1, 0};
    int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

    task automatic ref_run(input int n, input int lat, input int mode,
                           output bit f, output int fa, output int fe, output int cyc);
        logic [DW-1:0] m [16];
        logic [DW-1:0] v;
        int a;
        exp_q.delete();
        f = 0; fa = 0; fe = 0; cyc = 0;
        for (int e = 0; e < 6 && !f; e++) begin
            for (int k = 0; k < n && !f; k++) begin
                a = (el_down[e] != 0) ? n - 1 - k : k;
                if (el_rd[e] >= 0) begin
                    cyc += lat + 1;
                    v = fault_rd(m[a], a, mode);
                    exp_q.push_back({1'b0, 8'(a), 32'h0});
                    if (v !== {DW{el_rd[e][0]}}) begin f = 1; fa = a; fe = e; end
                end else begin
                    cyc += 1;
                end
                if (!f && el_wr[e] >= 0) begin
                    m[a] = {DW{el_wr[e][0]}};
                    if (mode == 2 && a == 3 && el_wr[e] == 0) m[2][0] = 1'b0;
                    exp_q.push_back({1'b1, 8'(a), {DW{el_wr[e][0]}}, {DW{1'b1}}});
                end
            end
        end
    endtask

    task automatic pulse(input bit w, input bit v);
        if (w) start_b = v; else start_a = v;
    endtask

    task automatic run(input bit w, input int mode, input bit extra, input string name);
        bit ef, got;
        int ea, ee, ec, b0, r0, q0, cyc, bad;
        ref_run(w ? int'(NB) : int'(NA), w ? int'(LB) : int'(LA), mode, ef, ea, ee, ec);
        if (w) mode_b = mode; else mode_a = mode;
        @(negedge clk); #1;
        if (w) scr_b = 1'b1; else scr_a = 1'b1;
        @(negedge clk); #1;
        scr_a = 1'b0; scr_b = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk); #1;
        b0 = bcnt_of(w); r0 = rise_of(w); q0 = qsize_of(w);
        pulse(w, 1'b1);
        @(negedge clk); #1;
        pulse(w, 1'b0);
        tests++;
        if (done_of(w) !== 1'b0 || fail_of(w) !== 1'b0 || busy_of(w) !== 1'b1)
            $display("FAIL %s start: done=%0b fail=%0b busy=%0b, expected 0 0 1",
                     name, done_of(w), fail_of(w), busy_of(w));
        cyc = 0; got = 0;
        while (!got && cyc < 5000) begin
            @(negedge clk); #1;
            cyc++;
            if (extra) pulse(w, (cyc == 10 || cyc == 50));
            if (done_of(w)) got = 1;
        end
        pulse(w, 1'b0);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s done_timeout: done=0 after %0d cycles, expected 1", name, cyc);
        end
        tests++;
        if (busy_of(w) !== 1'b0 || fail_of(w) !== ef) begin
            fails++;
            $display("FAIL %s status: busy=%0b fail=%0b, expected busy=0 fail=%0b",
                     name, busy_of(w), fail_of(w), ef);
        end
        tests++;
        if (faddr_of(w) != (ef ? ea : 0) || felem_of(w) != (ef ? ee : 0)) begin
            fails++;
            $display("FAIL %s fail_loc: addr=%0d elem=%0d, expected addr=%0d elem=%0d",
                     name, faddr_of(w), felem_of(w), ef ? ea : 0, ef ? ee : 0);
        end
        tests++;
        if (bcnt_of(w) - b0 != ec || rise_of(w) - r0 != 1) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d in %0d intervals, expected %0d in 1",
                     name, bcnt_of(w) - b0, rise_of(w) - r0, ec);
        end
        bad = -1;
        if (qsize_of(w) - q0 != exp_q.size()) bad = 1 << 20;
        for (int i = 0; i < exp_q.size() && bad < 0; i++)
            if (qat_of(w, q0 + i) !== exp_q[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            if (bad == (1 << 20))
                $display("FAIL %s trace_len: got %0d accesses, expected %0d",
                         name, qsize_of(w) - q0, exp_q.size());
            else
                $display("FAIL %s trace[%0d]: got %h, expected %h",
                         name, bad, qat_of(w, q0 + bad), exp_q[bad]);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({a_busy, a_done, a_fail, a_faddr, a_felem} !== '0) begin
            fails++;
            $display("FAIL reset_status: got %b, expected all 0", {a_busy, a_done, a_fail, a_faddr, a_felem});
        end
        tests++;
        if ({a_en, a_men, a_wen, a_ren, a_addr, a_din, a_bm} !== '0) begin
            fails++;
            $display("FAIL reset_port: got %h, expected 0", {a_en, a_men, a_wen, a_ren, a_addr, a_din, a_bm});
        end
        tests++;
        if ({b_busy, b_done, b_fail, b_en, b_men, b_addr, b_din} !== '0) begin
            fails++;
            $display("FAIL reset_b: got %h, expected 0", {b_busy, b_done, b_fail, b_en, b_men, b_addr, b_din});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_pass;  run(1'b0, 0, 1'b0, "clean");    endtask
    task automatic test_stuck_at;    run(1'b0, 1, 1'b0, "stuck_at");  endtask
    task automatic test_coupling;    run(1'b0, 2, 1'b0, "coupling");  endtask

    task automatic test_latency2;
        run(1'b1, 0, 1'b0, "lat2");
        tests++;
        if (max_addr_b >= int'(NB) || wt_err_b) begin
            fails++;
            $display("FAIL lat2_addr_wt: max_addr=%0d wt_err=%0b, expected <%0d and 0",
                     max_addr_b, wt_err_b, NB);
        end
    endtask

    task automatic test_reset_mid;
        mode_a = 0;
        @(negedge clk); #1;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        repeat ($urandom_range(115, 135)) @(negedge clk);
        #1;
        tests++;
        if (a_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: busy=%0b before abort, expected 1", a_busy);
        end
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({a_busy, a_done, a_fail, a_faddr, a_felem, a_en, a_men, a_wen, a_ren, a_addr, a_din, a_bm} !== '0) begin
            fails++;
            $display("FAIL mid_reset: outputs %h, expected 0",
                     {a_busy, a_done, a_fail, a_faddr, a_felem, a_en, a_men, a_wen, a_ren, a_addr, a_din, a_bm});
        end
        @(negedge clk); #1;
        rst = 1'b0;
        run(1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        run(1'b0, 1, 1'b0, "prefail");
        run(1'b0, 0, 1'b1, "restart_busy_start");
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++)
            run(1'(($urandom_range(0, 1))), int'($urandom_range(0, 2)), 1'b0, "random");
    endtask

    task automatic test_port_rules;
        tests++;
        if (rule_err_a || rule_err_b) begin
            fails++;
            $display("FAIL port_rules: err_a=%0b err_b=%0b, expected 0 0", rule_err_a, rule_err_b);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_stuck_at();
        test_coupling();
        test_latency2();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_port_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
